// File: rtl/vedic_mul_8bit_seq.sv
// Sequential 8x8 unsigned multiplier: a single 4x4 Vedic core is time-shared across the
// four nibble partial products, which are shifted and summed into a 16-bit accumulator.

module vedic_mul_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] prod
);

    // Urdhva-tiryagbhyam 2x2 cell built from AND terms and half adders.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] u, input logic [1:0] v);
        logic       c1;
        logic [3:0] r;
        r[0] = u[0] & v[0];
        r[1] = (u[1] & v[0]) ^ (u[0] & v[1]);
        c1   = (u[1] & v[0]) & (u[0] & v[1]);
        r[2] = c1 ^ (u[1] & v[1]);
        r[3] = c1 & u[1] & v[1];
        return r;
    endfunction

    logic [3:0] q0, q1, q2, q3;
    logic [4:0] cross_sum;

    assign q0 = vedic_2x2(x[1:0], y[1:0]);
    assign q1 = vedic_2x2(x[3:2], y[1:0]);
    assign q2 = vedic_2x2(x[1:0], y[3:2]);
    assign q3 = vedic_2x2(x[3:2], y[3:2]);

    assign cross_sum = {1'b0, q1} + {1'b0, q2};
    assign prod      = {q3, q0} + {1'b0, cross_sum, 2'b00};

endmodule

module vedic_mul_8bit_seq #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e      state_q;
    logic [1:0]  step_q;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc_q;

    logic [3:0]  mul_x, mul_y;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;

    vedic_mul_4bit u_core (
        .x    (mul_x),
        .y    (mul_y),
        .prod (pp)
    );

    // Step selects which nibble pair feeds the core and how far its product is weighted.
    always_comb begin
        mul_x      = a_q[3:0];
        mul_y      = b_q[3:0];
        pp_shifted = {8'h00, pp};
        unique case (step_q)
            2'd0: begin
                mul_x      = a_q[3:0];
                mul_y      = b_q[3:0];
                pp_shifted = {8'h00, pp};
            end
            2'd1: begin
                mul_x      = a_q[7:4];
                mul_y      = b_q[3:0];
                pp_shifted = {4'h0, pp, 4'h0};
            end
            2'd2: begin
                mul_x      = a_q[3:0];
                mul_y      = b_q[7:4];
                pp_shifted = {4'h0, pp, 4'h0};
            end
            2'd3: begin
                mul_x      = a_q[7:4];
                mul_y      = b_q[7:4];
                pp_shifted = {pp, 8'h00};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        acc_q  <= 16'h0000;
                        step_q <= 2'd0;
                        if (ZERO_BYPASS && (a == 8'h00 || b == 8'h00)) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StMul;
                        end
                    end
                end
                StMul: begin
                    acc_q  <= acc_q + pp_shifted;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign out_valid   = (state_q == StDone);
    assign p           = acc_q;

endmodule

// File: tb/tb_vedic_mul_8bit_seq.sv
// Randomized scoreboard bench for vedic_mul_8bit_seq: driver pushes a*b expectations,
// monitor pops and compares on each completed product.

module tb_vedic_mul_8bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid, out_ready;
    logic [7:0]  a, b;
    logic        start_ready, out_valid, busy;
    logic [15:0] p;

    // Second instance without zero bypass.
    logic        sv2;
    logic [7:0]  a2, b2;
    logic        sr2, ov2, busy2;
    logic [15:0] p2;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          acc_cycle;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   n_flushed = 0;
    int   ready_mode = 1;  // 0 random, 1 always high, 2 held low

    vedic_mul_8bit_seq #(.ZERO_BYPASS(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .busy        (busy)
    );

    vedic_mul_8bit_seq #(.ZERO_BYPASS(1'b0)) dut_nb (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv2),
        .start_ready (sr2),
        .a           (a2),
        .b           (b2),
        .out_valid   (ov2),
        .out_ready   (1'b1),
        .p           (p2),
        .busy        (busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every presented product against the head of the queue.
    initial begin
        bit in_prod = 0;
        bit just_popped = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_prod     = 0;
                just_popped = 0;
            end else begin
                if (just_popped) begin
                    check("idle_after_pop", {29'd0, out_valid, start_ready, busy}, 32'b010);
                    just_popped = 0;
                end
                if (in_prod && !out_valid) begin
                    check("out_valid_dropped", out_valid, 1);
                    in_prod = 0;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", out_valid, 0);
                    end else begin
                        check("no_reaccept_in_done", start_ready, 0);
                        if (!in_prod) begin
                            check("latency", cycle - exp_q[0].acc_cycle, exp_q[0].lat);
                            check("product", p, exp_q[0].prod);
                            in_prod = 1;
                        end else begin
                            check("p_stable", p, exp_q[0].prod);
                        end
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            n_out++;
                            in_prod     = 0;
                            just_popped = 1;
                        end
                    end
                end
            end
        end
    end

    // Garbage on the inputs while busy must be ignored; quiet when idle.
    task automatic junk();
        if (!start_ready) begin
            start_valid = 1'($urandom);
            a           = 8'($urandom);
            b           = 8'($urandom);
        end else begin
            start_valid = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        int   n = 0;
        exp_t e;
        while (!start_ready && n < 200) begin
            junk();
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            check("start_ready_timeout", start_ready, 1);
            return;
        end
        a           = x;
        b           = y;
        start_valid = 1'b1;
        e.prod      = 16'(int'(x) * int'(y));
        // A bypassed zero lands in DONE on the accept edge itself.
        e.lat       = (x == 8'd0 || y == 8'd0) ? 0 : 4;
        e.acc_cycle = cycle + 1;
        exp_q.push_back(e);
        n_acc++;
        @(negedge clk);
        junk();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            junk();
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        junk();
    endtask

    initial begin
        int c0;
        int n;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        a           = 8'h00;
        b           = 8'h00;
        sv2         = 1'b0;
        a2          = 8'h00;
        b2          = 8'h00;
        #1;
        check("rst_p", p, 16'h0000);
        check("rst_flags", {29'd0, out_valid, busy, start_ready}, 32'b001);
        check("rst_nb_flags", {29'd0, ov2, busy2, sr2}, 32'b001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Without bypass a zero operand still takes four MUL steps.
        a2 = 8'h00; b2 = 8'h7A; sv2 = 1'b1;
        c0 = cycle + 1;
        @(negedge clk);
        sv2 = 1'b0; a2 = 8'h55; b2 = 8'hAA;
        n = 0;
        while (!ov2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("nb_zero_latency", cycle - c0, 4);
        check("nb_zero_p", p2, 16'h0000);
        @(negedge clk);
        a2 = 8'h0B; b2 = 8'h0E; sv2 = 1'b1;
        @(negedge clk);
        sv2 = 1'b0;
        n = 0;
        while (!ov2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("nb_p", p2, 16'h009A);

        ready_mode = 1;
        issue(8'hB5, 8'hE3);
        drain();
        ready_mode = 2;
        issue(8'hFF, 8'hFF);
        repeat (9) begin
            junk();
            @(negedge clk);
        end
        ready_mode = 1;
        drain();
        issue(8'h00, 8'h7A);
        drain();
        issue(8'h0B, 8'h0E);
        drain();

        // Reset mid-multiply: the pending product must never appear.
        issue(8'h9D, 8'h5B);
        @(negedge clk);
        start_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        n_flushed++;
        #1;
        check("abort_p", p, 16'h0000);
        check("abort_flags", {29'd0, out_valid, busy, start_ready}, 32'b001);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(8'h9D, 8'h5B);
        drain();

        ready_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            if ($urandom_range(0, 15) == 0) x = 8'h00;
            if ($urandom_range(0, 15) == 0) y = 8'h00;
            if ($urandom_range(0, 31) == 0) x = 8'hFF;
            if ($urandom_range(0, 31) == 0) y = 8'hFF;
            issue(x, y);
            repeat ($urandom_range(0, 2)) begin
                junk();
                @(negedge clk);
            end
        end
        drain();
        start_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("out_count", n_out, n_acc - n_flushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
